// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM states, default device ID and ACK level.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_DATA,
        S_DATA_ACK,
        S_RD_DATA,
        S_RD_NA,
        S_IGNORE
    } state_t;

    localparam logic [7:0] SCCBID_DEFAULT = 8'h60;
    localparam logic       ACK_LEVEL      = 1'b0;

    // Open-drain: the only way to put a 0 on SIO_D is to pull it low.
    function automatic logic pulls_low(input logic level);
        return level == 1'b0;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizer plus delay flop for one SCCB line; reports level and single-cycle rise/fall.
module sccb_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    // Idle SCCB lines sit high, so reset to 1 to avoid a phantom edge on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
            r_dly  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage shifts from the previous cycle's value.
            r_sync <= {r_sync[STAGES-2:0], i_line};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase/2-phase writes and 2-phase reads into a byte register port.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0] SCCBID      = SCCBID_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soic,
    input  logic       soid_i,
    output logic       soid_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic w_c_lvl, w_c_rise, w_c_fall;
    logic w_d_lvl, w_d_rise, w_d_fall;

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sync_c (
        .clk(clk), .reset(reset), .i_line(soic),
        .o_level(w_c_lvl), .o_rise(w_c_rise), .o_fall(w_c_fall)
    );

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
        .clk(clk), .reset(reset), .i_line(soid_i),
        .o_level(w_d_lvl), .o_rise(w_d_rise), .o_fall(w_d_fall)
    );

    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_flag, w_flag_nxt;       // ACK states: 9th rise seen; RD_DATA: 8 bits sent
    logic       r_rd_mode, w_rd_mode_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic       w_sub_ld, w_wr_ld;
    logic [7:0] r_sub, r_wr_addr, r_wr_data;

    logic       w_start, w_stop, w_last_bit;
    logic [7:0] w_byte;

    assign w_start    = w_d_fall & w_c_lvl;
    assign w_stop     = w_d_rise & w_c_lvl;
    assign w_byte     = {r_shift[6:0], w_d_lvl};
    assign w_last_bit = (r_cnt == 3'd7);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_flag_nxt    = r_flag;
        w_rd_mode_nxt = r_rd_mode;
        w_oe_nxt      = r_oe;
        w_wr_en_nxt   = 1'b0;
        w_sub_ld      = 1'b0;
        w_wr_ld       = 1'b0;

        if (w_start) begin
            w_state_nxt = S_ID;
            w_cnt_nxt   = 3'd0;
            w_flag_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_flag_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
        end else if (w_c_rise) begin
            case (r_state)
                S_ID, S_SUB, S_DATA: begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (w_last_bit) begin
                        if (r_state == S_SUB) begin
                            w_state_nxt = S_SUB_ACK;
                            w_sub_ld    = 1'b1;
                        end else if (r_state == S_DATA) begin
                            w_state_nxt = S_DATA_ACK;
                            w_wr_en_nxt = 1'b1;
                            w_wr_ld     = 1'b1;
                        end else if (w_byte == {SCCBID[7:1], 1'b0}) begin
                            w_state_nxt   = S_ID_ACK;
                            w_rd_mode_nxt = 1'b0;
                        end else if (w_byte == {SCCBID[7:1], 1'b1}) begin
                            w_state_nxt   = S_ID_ACK;
                            w_rd_mode_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_DATA_ACK: w_flag_nxt = 1'b1;
                S_RD_DATA: begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (w_last_bit) w_flag_nxt = 1'b1;
                end
                S_RD_NA: w_state_nxt = S_IGNORE;
                default: ;
            endcase
        end else if (w_c_fall) begin
            case (r_state)
                S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                    if (!r_flag) begin
                        w_oe_nxt = pulls_low(ACK_LEVEL);
                    end else begin
                        w_oe_nxt   = 1'b0;
                        w_flag_nxt = 1'b0;
                        w_cnt_nxt  = 3'd0;
                        if (r_state == S_SUB_ACK) begin
                            w_state_nxt = S_DATA;
                        end else if (r_state == S_DATA_ACK) begin
                            w_state_nxt = S_IGNORE;
                        end else if (r_rd_mode) begin
                            // Read data is captured on the fall ending the ID ACK and its MSB driven at once.
                            w_state_nxt = S_RD_DATA;
                            w_shift_nxt = rd_data;
                            w_oe_nxt    = pulls_low(rd_data[7]);
                        end else begin
                            w_state_nxt = S_SUB;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (r_flag) begin
                        w_oe_nxt    = 1'b0;
                        w_flag_nxt  = 1'b0;
                        w_state_nxt = S_RD_NA;
                    end else begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_oe_nxt    = pulls_low(r_shift[6]);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: only control/data registers are reset here; there is no memory array to clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_cnt     <= 3'd0;
            r_flag    <= 1'b0;
            r_rd_mode <= 1'b0;
            r_oe      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_sub     <= 8'h00;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flag    <= w_flag_nxt;
            r_rd_mode <= w_rd_mode_nxt;
            r_oe      <= w_oe_nxt;
            r_wr_en   <= w_wr_en_nxt;
            if (w_sub_ld) r_sub <= w_byte;
            if (w_wr_ld) begin
                r_wr_addr <= r_sub;
                r_wr_data <= w_byte;
            end
        end
    end

    assign soid_oe = r_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_sub;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-level SCCB master, open-drain line model and a transaction-level reference.
module tb_sccb_slave;

    localparam int T = 6;   // quarter SIO_C period in clk cycles (SIO_C = clk/24)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       soic = 1'b1;
    logic       sda_m = 1'b1;
    logic       soid_i;
    logic       soid_oe;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       busy;

    logic [7:0] mem [256];

    assign soid_i  = sda_m & ~soid_oe;
    assign rd_data = mem[rd_addr];

    sccb_slave dut (
        .clk(clk), .reset(reset), .soic(soic), .soid_i(soid_i), .soid_oe(soid_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          n_wr = 0;
    logic [15:0] exp_wr_q[$];
    int          m_sub = 0;
    bit          oe_valid = 1'b0;
    bit          exp_oe = 1'b0;
    logic [7:0]  last_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the line drive and the write strobe against the model.
    task automatic compare_loop();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (oe_valid) check("soid_oe", soid_oe, exp_oe);
                if (wr_en) begin
                    n_wr++;
                    if (exp_wr_q.size() == 0) begin
                        check("wr_en_unexpected", wr_en, 0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("wr_addr", wr_addr, e[15:8]);
                        check("wr_data", wr_data, e[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        sda_m = 1'b1;
        step(T);
        soic = 1'b1;
        step(2 * T);
        sda_m = 1'b0;
        step(2 * T);
        soic = 1'b0;
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        step(T);
        soic = 1'b1;
        step(2 * T);
        sda_m = 1'b1;
        step(2 * T);
    endtask

    task automatic m_bit(input bit d, input bit eo, output bit r);
        step(T);
        sda_m = d;
        step(T);
        soic = 1'b1;
        step(T);
        exp_oe   = eo;
        oe_valid = 1'b1;
        step(T);
        r        = soid_i;
        oe_valid = 1'b0;
        soic     = 1'b0;
    endtask

    // nbits < 8 stops mid-byte with no ACK slot.
    task automatic m_byte(input logic [7:0] tx, input bit rd, input logic [7:0] rexp,
                          input bit ack, input int nbits, output logic [7:0] rx);
        bit r;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (rd) m_bit(1'b1, ~rexp[7-i], r);
            else    m_bit(tx[7-i], 1'b0, r);
            rx = {rx[6:0], r};
        end
        if (nbits == 8) m_bit(1'b1, ack, r);
    endtask

    // Transaction-level reference: which bytes are ACKed, what is written, what is read back.
    task automatic run_txn(input logic [7:0] b0, b1, b2, b3, input int n,
                           input int cut_bits, input bit stop);
        logic [7:0] bs [4];
        logic [7:0] rx, rexp;
        bit         valid, rdm, ack, drive;
        int         nb;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        valid = (b0[7:1] == 7'h30);
        rdm   = b0[0];
        m_start();
        for (int i = 0; i < n; i++) begin
            nb    = (i == n - 1) ? cut_bits : 8;
            ack   = 1'b0;
            drive = 1'b0;
            rexp  = 8'h00;
            if (valid && rdm) begin
                if (i == 0) ack = 1'b1;
                else if (i == 1) begin
                    drive = 1'b1;
                    rexp  = mem[m_sub];
                end
            end else if (valid) begin
                ack = (i <= 2);
                if (nb == 8 && i == 1) m_sub = bs[1];
                if (nb == 8 && i == 2) exp_wr_q.push_back({m_sub[7:0], bs[2]});
            end
            m_byte(bs[i], drive, rexp, ack, nb, rx);
            if (drive && nb == 8) begin
                check("rd_byte", rx, rexp);
                last_rx = rx;
            end
        end
        if (stop) m_stop();
        step(4);
        check("busy", busy, !stop);
        check("rd_addr", rd_addr, m_sub);
        check("wr_pending", exp_wr_q.size(), 0);
    endtask

    initial begin
        int         wr0, kind;
        logic [7:0] rs, rd, re, wid;
        bit         r;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h0A] = 8'h26;
        fork
            compare_loop();
        join_none

        step(5);
        check("rst_oe", soid_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step(5);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);

        // 3-phase write
        wr0 = n_wr;
        run_txn(8'h60, 8'h12, 8'h80, 8'h00, 3, 8, 1'b1);
        check("t1_wr_count", n_wr - wr0, 1);
        check("t1_wr_addr", wr_addr, 8'h12);
        check("t1_wr_data", wr_data, 8'h80);

        // Foreign ID: ignored, busy until STOP
        wr0 = n_wr;
        run_txn(8'h42, 8'h12, 8'h80, 8'h00, 3, 8, 1'b0);
        m_stop();
        step(4);
        check("t2_busy_after_stop", busy, 0);
        check("t2_wr_count", n_wr - wr0, 0);

        // 2-phase write then read
        wr0 = n_wr;
        run_txn(8'h60, 8'h0A, 8'h00, 8'h00, 2, 8, 1'b1);
        check("t3_rd_addr", rd_addr, 8'h0A);
        run_txn(8'h61, 8'h00, 8'h00, 8'h00, 2, 8, 1'b1);
        check("t3_rx", last_rx, 8'h26);
        check("t3_wr_count", n_wr - wr0, 0);

        // Partial SUB aborted by repeated START
        wr0 = n_wr;
        run_txn(8'h60, 8'hA5, 8'h00, 8'h00, 2, 4, 1'b0);
        run_txn(8'h60, 8'h3C, 8'h32, 8'h00, 3, 8, 1'b1);
        check("t4_wr_count", n_wr - wr0, 1);

        // Reset during DATA bit 5
        wr0 = n_wr;
        m_start();
        m_byte(8'h60, 1'b0, 8'h00, 1'b1, 8, rs);
        m_byte(8'h11, 1'b0, 8'h00, 1'b1, 8, rs);
        m_sub = 8'h11;
        for (int i = 0; i < 4; i++) m_bit(1'b0, 1'b0, r);
        step(T);
        sda_m = 1'b0;
        step(T);
        soic = 1'b1;
        step(T);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_addr", rd_addr, 0);
        check("t5_rst_wr_en", wr_en, 0);
        check("t5_rst_oe", soid_oe, 0);
        m_sub = 0;
        step(3);
        sda_m = 1'b1;
        step(3);
        reset = 1'b0;
        step(T);
        run_txn(8'h60, 8'hFF, 8'h01, 8'h00, 3, 8, 1'b1);
        check("t5_wr_count", n_wr - wr0, 1);

        // Extra data byte is neither written nor ACKed
        wr0 = n_wr;
        run_txn(8'h60, 8'hD3, 8'h8F, 8'h55, 4, 8, 1'b1);
        check("t6_wr_count", n_wr - wr0, 1);

        // Randomized mix
        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(0, 4));
            rs   = 8'($urandom);
            rd   = 8'($urandom);
            re   = 8'($urandom);
            wid  = 8'($urandom);
            if (wid[7:1] == 7'h30) wid = wid ^ 8'h80;
            case (kind)
                0:       run_txn(8'h60, rs, rd, re, 3, 8, 1'b1);
                1:       run_txn(8'h60, rs, rd, re, 4, 8, 1'b1);
                2:       run_txn(8'h60, rs, rd, re, 2, 8, 1'b1);
                3:       run_txn(8'h61, rs, rd, re, 2, 8, 1'b1);
                default: run_txn(wid, rs, rd, re, 3, 8, 1'b1);
            endcase
        end

        step(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
# sccb_slave

SCCB responder: receives 3-phase write and 2-phase write / 2-phase read transactions on SIO_C/SIO_D and turns them into a byte-wide register access port. It is the target-side counterpart of the `sccb` camera-configuration master. It serves as the OV2640 stand-in in system simulation and as an FPGA-side configuration target. SIO_D is open-drain: the block only ever pulls low.

## Interface

Parameters:
- `SCCBID`, default 8'h60: 7-bit write ID in bits [7:1]. Write address is SCCBID; read address is SCCBID|1.
- `SYNC_STAGES`, default 2: synchronizer depth for `soic` and `soid_i`. Minimum 2.

Ports:
- `clk`  in  1: system clock. Must run at ≥16× the SIO_C rate.
- `reset`  in  1: asynchronous, active-high.
- `soic`  in  1: SIO_C from the master.
- `soid_i`  in  1: SIO_D line value, after the pad.
- `soid_oe`  out  1: 1 = pull SIO_D low. 0 = release.
- `wr_en`  out  1: one-cycle write strobe.
- `wr_addr`  out  8: sub-address of the write.
- `wr_data`  out  8: data of the write.
- `rd_addr`  out  8: current sub-address register.
- `rd_data`  in  8: read data for `rd_addr`; sampled combinationally.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation

- `soic` and `soid_i` pass through SYNC_STAGES flops, then one delay flop. Edges are detected on the synchronized pair.
- START = SIO_D falls while SIO_C is high. STOP = SIO_D rises while SIO_C is high.
- Bits are sampled MSB first on each SIO_C rise into an 8-bit shift register with a 3-bit counter.
- `soid_oe` changes only on SIO_C falls.
- FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD_DATA, RD_NA, IGNORE.
- START from any state → ID, counter cleared.
- STOP from any state → IDLE, `soid_oe`=0.
- ID, 8th bit:
  - Byte == SCCBID → ID_ACK, write mode.
  - Byte == SCCBID|1 → ID_ACK, read mode.
  - Otherwise → IGNORE.
- ID_ACK, write mode → SUB.
- SUB, 8th bit → SUB_ACK. The sub-address register (`rd_addr`) loads on the same sample.
- SUB_ACK → DATA.
- DATA, 8th bit:
  - `wr_en` pulses with `wr_addr`=sub-address and `wr_data`=byte.
  - State → DATA_ACK.
- DATA_ACK → IGNORE.
- No address auto-increment. Bytes after the first data byte are neither written nor acknowledged.
- ID_ACK, read mode → RD_DATA. `rd_data` is latched into the shift register on the SIO_C fall that ends the ACK clock.
- RD_DATA:
  - Each SIO_C fall drives `soid_oe` = ~current bit, MSB first.
  - After the 8th bit, the next fall releases the line → RD_NA.
- RD_NA: the master's NA/ACK bit is sampled and ignored → IGNORE.
- ACK generation: in every ACK state, the SIO_C fall after the 8th rise sets `soid_oe`=1. The fall after the 9th rise clears it.
- A 2-phase write (ID, SUB, STOP) updates only the sub-address register. No `wr_en` is issued.

## Timing

- Reset values: `soid_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, state IDLE.
- Line edge to internal detection: SYNC_STAGES+1 clk cycles.
- `wr_en` is high exactly one cycle, in the cycle the 8th DATA rise is detected. It precedes the ACK.
- `soid_oe` update: SYNC_STAGES+2 clk after the SIO_C fall. This is within the SIO_C low phase given the ≥16× clock requirement.
- Simultaneous START/STOP and SIO_C edge: impossible, because SIO_D only changes while SIO_C is high for START/STOP. If the synchronized pair shows both edges in one cycle, START/STOP takes priority.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). No partial `wr_en` is issued. The block waits for the next START.
- STOP during ACK or read drive: `soid_oe` clears in the same cycle as the STOP detection.

## Structure

- Shared package `sccb_pkg`:
  - FSM state enum.
  - Default SCCBID constant 8'h60.
  - ACK level constant (1'b0).
- One natural sub-module: `sccb_line_sync`, used for both lines. It contains the synchronizer plus the delay flop and outputs rise/fall/level.
- FSM, shift register and counter stay in `sccb_slave`.

## Test plan

- Write 0x60, 0x12, 0x80, STOP → exactly one `wr_en` with addr 0x12, data 0x80. Three ACK low pulses, each covering the 9th SIO_C high. `busy` falls after STOP.
- Write to ID 0x42, 0x12, 0x80 → `soid_oe` never asserted. No `wr_en`. `busy` high until STOP.
- 2-phase write 0x60, 0x0A, STOP, then read 0x61 with `rd_data`=0x26 → `rd_addr`=0x0A. SIO_D carries 0x26 MSB first. Released on the 9th clock. No `wr_en`.
- START, 0x60, 4 bits of SUB, repeated START, then 0x60, 0x3C, 0x32, STOP → single `wr_en` with addr 0x3C, data 0x32.
- `reset` pulse during DATA bit 5 of 0x60/0x11/0x00 → outputs 0 at once. No `wr_en`. The next full write 0x60/0xFF/0x01 writes normally.
- 0x60, 0xD3, 0x8F, 0x55, STOP → one `wr_en` (0xD3, 0x8F). The fourth byte gets no ACK.
